led_display_mode_sequencer: RTL and testbench
=============================================

Name: led_display_mode_sequencer

Overview:
Controller that owns the 4-bit mode input of the LED pattern generator. It accepts manual requests (direct select, next, prev) and an automatic dwell-timer cycle, and defers every mode change to a frame boundary so a frame never mixes two patterns. The boundary is detected by observing the generator's row handshake. The block sits between the board control logic (buttons/switches/UART) and led_display_pattern_gen.

Parameters:
SYS_CLK_FREQ, 100_000_000, system clock in Hz; sets the 1 ms prescaler.
SIMULATION, 0, when 1 the ms prescaler divides by 100 instead of SYS_CLK_FREQ/1000.
NUM_MODES, 10, number of valid modes (0..NUM_MODES-1); mode 0 is OFF.
DWELL_MS, 5000, auto-cycle dwell time per mode, in ms ticks.
FRAME_TIMEOUT, 65535, max cycles in PENDING before a forced commit.

Ports:
clk_in  in  1  system clock
reset_in  in  1  asynchronous, active-high reset
auto_en_in  in  1  level; enables auto-cycling
next_in  in  1  single-cycle pulse; request mode+1
prev_in  in  1  single-cycle pulse; request mode-1
mode_sel_in  in  4  direct mode request value
mode_sel_valid_in  in  1  qualifies mode_sel_in for one cycle
row_valid_in  in  1  generator row_valid (observed)
row_address_in  in  4  generator row address (observed)
mode_out  out  4  committed mode to the generator mode_in
switching_out  out  1  high while a change is pending or blanking
sel_error_out  out  1  one-cycle pulse on an out-of-range mode_sel_in
frame_count_out  out  16  frames completed in the current mode, saturating

Behaviour:
- Reset (async assert, sync release): mode_out=0, switching_out=0, sel_error_out=0, frame_count_out=0, target=0, state=RUN, timers=0.
- Frame end: row_valid_in && row_address_in==4'hF, sampled on a clock edge.
- Request priority when several arrive in one cycle: mode_sel_valid_in > next_in > prev_in > dwell expiry. Only the winner takes effect.
- next: target=(cur+1), wraps NUM_MODES-1 to 0. prev: target=(cur-1), wraps 0 to NUM_MODES-1. "cur" is target while switching, else mode_out.
- Auto: the dwell counter counts ms ticks while auto_en_in=1 and state=RUN. At DWELL_MS it requests the next mode, skipping 0 (NUM_MODES-1 wraps to 1). The counter clears on every commit and whenever auto_en_in=0.
- mode_sel_in >= NUM_MODES: request ignored, sel_error_out pulses 1 cycle.
- A request equal to mode_out while in RUN is ignored (no state change).
- FSM:
  - RUN: on an accepted request, latch target and go to PENDING; switching_out=1 from the next cycle.
  - PENDING: on frame end, or when the timeout counter reaches FRAME_TIMEOUT, go to BLANK if the feature is enabled, else COMMIT.
  - BLANK: see Optional Feature.
  - COMMIT: one cycle; mode_out<=target, frame_count_out<=0, dwell cleared, switching_out<=0, return to RUN.
- New requests in PENDING or BLANK overwrite target without restarting the wait.
- Latency: mode_out updates exactly 2 cycles after the qualifying frame-end edge (PENDING to COMMIT to register).
- frame_count_out increments on each frame end in RUN and saturates at 16'hFFFF.

Optional Feature:
LED_SEQ_BLANK_FRAME_EN
- Defined: PENDING goes to BLANK, which drives mode_out=0 until the next frame end (same timeout rule), then COMMIT. This gives one dark frame between patterns.
- Undefined: BLANK does not exist, and PENDING goes directly to COMMIT.

Decomposition:
- Shared led_display_pkg gains:
  - MODE_* constants moved out of the generator as a typedef'd 4-bit enum, mode_t
  - GL_NUM_MODES
  - GL_LAST_ROW_ADDR (4'hF)
- The generator and the sequencer both import these.
- One sub-module: led_display_ms_tick, a parameterised prescaler emitting a 1-cycle tick every SYS_CLK_FREQ/1000 cycles (100 when SIMULATION=1). The FSM and counters stay in the top module.

Test Plan:
- Reset mid-PENDING: reset_in=1 asserted asynchronously -> mode_out=0 and switching_out=0 immediately, with no clock edge needed.
- mode_sel_in=3 with valid, then frame end (row_address_in=F, row_valid_in=1) 40 cycles later -> switching_out=1 throughout, mode_out=3 two cycles after the frame end (feature off).
- mode_out=9, next_in pulse -> target 0; prev_in at mode_out=0 -> mode 9. next_in and prev_in in the same cycle -> next wins.
- SIMULATION=1, DWELL_MS=3, auto_en_in=1, frame ends every 50 cycles -> mode sequence 1,2,...,9,1, each held for about 300 cycles plus wait-to-frame; mode 0 never appears.
- mode_sel_in=12 -> sel_error_out high for exactly 1 cycle, mode_out unchanged. FRAME_TIMEOUT=20 with no frame ends -> commit 20 cycles after entering PENDING.
- LED_SEQ_BLANK_FRAME_EN defined, request mode 5 from 2 -> mode_out 2, then 0 for one frame, then 5. frame_count_out reads 0 after commit and increments per frame end.

Source files
------------

// File: rtl/led_display_pkg.sv
// Shared definitions for the LED display blocks: the pattern generator's
// mode encoding, the last scan row address, the sequencer FSM states and the
// mode wrap helpers.
// Optional feature macro: LED_SEQ_BLANK_FRAME_EN adds the BLANK state.
package led_display_pkg;

  localparam int unsigned GL_NUM_MODES     = 10;
  localparam logic [3:0]  GL_LAST_ROW_ADDR = 4'hF;

  // Pattern generator modes; MODE_OFF must stay at zero.
  typedef enum logic [3:0] {
    MODE_OFF      = 4'd0,
    MODE_SOLID    = 4'd1,
    MODE_CHECKER  = 4'd2,
    MODE_HBARS    = 4'd3,
    MODE_VBARS    = 4'd4,
    MODE_GRADIENT = 4'd5,
    MODE_SCROLL   = 4'd6,
    MODE_RAIN     = 4'd7,
    MODE_SPARKLE  = 4'd8,
    MODE_TEST     = 4'd9
  } mode_t;

`ifdef LED_SEQ_BLANK_FRAME_EN
  typedef enum logic [1:0] {
    SEQ_RUN     = 2'd0,
    SEQ_PENDING = 2'd1,
    SEQ_BLANK   = 2'd2,
    SEQ_COMMIT  = 2'd3
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    SEQ_RUN     = 2'd0,
    SEQ_PENDING = 2'd1,
    SEQ_COMMIT  = 2'd3
  } seq_state_t;
`endif

  // Next mode, wrapping the last mode back to OFF.
  function automatic logic [3:0] mode_next(input logic [3:0] cur, input logic [3:0] last);
    return (cur >= last) ? 4'd0 : 4'(cur + 4'd1);
  endfunction

  // Previous mode, wrapping OFF to the last mode.
  function automatic logic [3:0] mode_prev(input logic [3:0] cur, input logic [3:0] last);
    return (cur == 4'd0) ? last : 4'(cur - 4'd1);
  endfunction

  // Auto-cycle step: like mode_next but never lands on OFF.
  function automatic logic [3:0] mode_next_auto(input logic [3:0] cur, input logic [3:0] last);
    return (cur >= last) ? 4'd1 : 4'(cur + 4'd1);
  endfunction

endpackage

// File: rtl/led_display_mode_sequencer_if.sv
// Control/observation bundle of the mode sequencer.
//   master : board control side (drives requests and the observed row handshake)
//   slave  : led_display_mode_sequencer
interface led_display_mode_sequencer_if;
  import led_display_pkg::*;

  logic        auto_en_in;
  logic        next_in;
  logic        prev_in;
  logic [3:0]  mode_sel_in;
  logic        mode_sel_valid_in;
  logic        row_valid_in;
  logic [3:0]  row_address_in;
  logic [3:0]  mode_out;
  logic        switching_out;
  logic        sel_error_out;
  logic [15:0] frame_count_out;

  modport master (
    output auto_en_in, next_in, prev_in, mode_sel_in, mode_sel_valid_in,
           row_valid_in, row_address_in,
    input  mode_out, switching_out, sel_error_out, frame_count_out
  );

  modport slave (
    input  auto_en_in, next_in, prev_in, mode_sel_in, mode_sel_valid_in,
           row_valid_in, row_address_in,
    output mode_out, switching_out, sel_error_out, frame_count_out
  );

endinterface

// File: rtl/led_display_ms_tick.sv
// Free-running millisecond prescaler: one-cycle tick_out every
// SYS_CLK_FREQ/1000 cycles, or every 100 cycles when SIMULATION != 0.
// Ports: clk_in, reset_in (async, active-high), tick_out (registered).
module led_display_ms_tick
  import led_display_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned SIMULATION   = 0
) (
  input  logic clk_in,
  input  logic reset_in,
  output logic tick_out
);

  localparam int unsigned DIV   = (SIMULATION != 0) ? 100 : SYS_CLK_FREQ / 1000;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap_c;

  // Divider counter and tick generation
  always_comb begin
    wrap_c = (cnt_q == CNT_W'(DIV - 1));
    cnt_d  = wrap_c ? '0 : CNT_W'(cnt_q + 1'b1);
    tick_d = wrap_c;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/led_display_mode_sequencer.sv
// Owns the pattern generator's mode input. Arbitrates manual requests
// (direct select > next > prev) and the auto dwell timer, then defers the
// change to a frame boundary seen on the generator's row handshake, with a
// timeout forcing the commit if frames stop.
// Ports: clk_in, reset_in (async, active-high), bus (slave modport):
//   requests auto_en/next/prev/mode_sel(+valid), observed row_valid/address,
//   outputs mode_out, switching_out, sel_error_out, frame_count_out.
// Optional feature macro: LED_SEQ_BLANK_FRAME_EN inserts one dark frame
// (mode_out=0) between the old and new pattern.
module led_display_mode_sequencer
  import led_display_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ  = 100_000_000,
  parameter int unsigned SIMULATION    = 0,
  parameter int unsigned NUM_MODES     = GL_NUM_MODES,
  parameter int unsigned DWELL_MS      = 5000,
  parameter int unsigned FRAME_TIMEOUT = 65535
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  led_display_mode_sequencer_if.slave   bus
);

  localparam logic [3:0]  LAST_MODE = 4'(NUM_MODES - 1);
  localparam int unsigned DWELL_W   = $clog2(DWELL_MS + 1);
  localparam int unsigned TO_W      = $clog2(FRAME_TIMEOUT + 1);

  seq_state_t         state_q, state_d;
  logic [3:0]         mode_q, mode_d;
  logic [3:0]         target_q, target_d;
  logic               switching_q, switching_d;
  logic               sel_error_q, sel_error_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TO_W-1:0]    timeout_q, timeout_d;

  logic               ms_tick;
  logic               frame_end_c;
  logic               dwell_expire_c;
  logic               wait_done_c;
  logic [TO_W-1:0]    timeout_inc_c;
  logic [3:0]         cur_mode_c;
  logic               req_valid_c;
  logic [3:0]         req_mode_c;

  led_display_ms_tick #(
    .SYS_CLK_FREQ (SYS_CLK_FREQ),
    .SIMULATION   (SIMULATION)
  ) u_ms_tick (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .tick_out (ms_tick)
  );

  // Request arbitration, dwell timer and FSM next-state/outputs
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    target_d      = target_q;
    switching_d   = switching_q;
    sel_error_d   = 1'b0;
    frame_count_d = frame_count_q;
    dwell_d       = dwell_q;
    timeout_d     = '0;
    req_valid_c   = 1'b0;

    frame_end_c    = bus.row_valid_in && (bus.row_address_in == GL_LAST_ROW_ADDR);
    timeout_inc_c  = TO_W'(timeout_q + 1'b1);
    wait_done_c    = frame_end_c || (timeout_inc_c >= TO_W'(FRAME_TIMEOUT));
    dwell_expire_c = (state_q == SEQ_RUN) && bus.auto_en_in && ms_tick &&
                     (dwell_q >= DWELL_W'(DWELL_MS - 1));

    // While a change is in flight, relative steps are taken from the target.
    cur_mode_c = (state_q == SEQ_RUN) ? mode_q : target_q;
    req_mode_c = cur_mode_c;

    if (bus.mode_sel_valid_in) begin
      if (bus.mode_sel_in > LAST_MODE) begin
        sel_error_d = 1'b1;
      end else begin
        req_valid_c = 1'b1;
        req_mode_c  = bus.mode_sel_in;
      end
    end else if (bus.next_in) begin
      req_valid_c = 1'b1;
      req_mode_c  = mode_next(cur_mode_c, LAST_MODE);
    end else if (bus.prev_in) begin
      req_valid_c = 1'b1;
      req_mode_c  = mode_prev(cur_mode_c, LAST_MODE);
    end else if (dwell_expire_c) begin
      req_valid_c = 1'b1;
      req_mode_c  = mode_next_auto(cur_mode_c, LAST_MODE);
    end

    // Dwell counts ms ticks only in RUN and restarts once it expires.
    if (!bus.auto_en_in) begin
      dwell_d = '0;
    end else if (dwell_expire_c) begin
      dwell_d = '0;
    end else if ((state_q == SEQ_RUN) && ms_tick) begin
      dwell_d = DWELL_W'(dwell_q + 1'b1);
    end

    unique case (state_q)
      SEQ_RUN: begin
        if (frame_end_c && (frame_count_q != 16'hFFFF)) begin
          frame_count_d = 16'(frame_count_q + 16'd1);
        end
        if (req_valid_c && (req_mode_c != mode_q)) begin
          target_d    = req_mode_c;
          switching_d = 1'b1;
          state_d     = SEQ_PENDING;
        end
      end

      SEQ_PENDING: begin
        timeout_d = timeout_inc_c;
        if (req_valid_c) begin
          target_d = req_mode_c;
        end
        if (wait_done_c) begin
          timeout_d = '0;
`ifdef LED_SEQ_BLANK_FRAME_EN
          mode_d  = 4'd0;
          state_d = SEQ_BLANK;
`else
          state_d = SEQ_COMMIT;
`endif
        end
      end

`ifdef LED_SEQ_BLANK_FRAME_EN
      SEQ_BLANK: begin
        timeout_d = timeout_inc_c;
        if (req_valid_c) begin
          target_d = req_mode_c;
        end
        if (wait_done_c) begin
          timeout_d = '0;
          state_d   = SEQ_COMMIT;
        end
      end
`endif

      SEQ_COMMIT: begin
        mode_d        = target_q;
        frame_count_d = '0;
        dwell_d       = '0;
        switching_d   = 1'b0;
        state_d       = SEQ_RUN;
        // A request landing on the commit cycle starts a fresh change.
        if (req_valid_c && (req_mode_c != target_q)) begin
          target_d    = req_mode_c;
          switching_d = 1'b1;
          state_d     = SEQ_PENDING;
        end
      end

      default: begin
        state_d = SEQ_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= SEQ_RUN;
      mode_q        <= 4'd0;
      target_q      <= 4'd0;
      switching_q   <= 1'b0;
      sel_error_q   <= 1'b0;
      frame_count_q <= 16'd0;
      dwell_q       <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      target_q      <= target_d;
      switching_q   <= switching_d;
      sel_error_q   <= sel_error_d;
      frame_count_q <= frame_count_d;
      dwell_q       <= dwell_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.mode_out        = mode_q;
  assign bus.switching_out   = switching_q;
  assign bus.sel_error_out   = sel_error_q;
  assign bus.frame_count_out = frame_count_q;

endmodule

// File: tb/tb_led_display_mode_sequencer.sv
// Self-checking bench for led_display_mode_sequencer: a table of single-cycle
// vectors plus hand-written sequences for frame wait, timeout, blank frame,
// auto-cycle and asynchronous reset.
module tb_led_display_mode_sequencer;

  localparam int unsigned FT = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_display_mode_sequencer_if bus ();

  led_display_mode_sequencer #(
    .SYS_CLK_FREQ  (100_000_000),
    .SIMULATION    (1),
    .NUM_MODES     (10),
    .DWELL_MS      (3),
    .FRAME_TIMEOUT (FT)
  ) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  typedef struct {
    logic        sv;
    logic [3:0]  sel;
    logic        nx;
    logic        pv;
    logic        rv;
    logic [3:0]  ra;
    logic [3:0]  m;
    logic        sw;
    logic        er;
    logic [15:0] fc;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [3:0] sel, input logic nx,
                              input logic pv, input logic rv, input logic [3:0] ra,
                              input logic [3:0] m, input logic sw, input logic er,
                              input logic [15:0] fc);
    vec_t v;
    v.sv = sv; v.sel = sel; v.nx = nx; v.pv = pv; v.rv = rv; v.ra = ra;
    v.m = m; v.sw = sw; v.er = er; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.next_in           = 1'b0;
    bus.prev_in           = 1'b0;
    bus.mode_sel_valid_in = 1'b0;
    bus.mode_sel_in       = 4'd0;
    bus.row_valid_in      = 1'b0;
    bus.row_address_in    = 4'd0;
  endtask

  task automatic frame_end();
    bus.row_valid_in   = 1'b1;
    bus.row_address_in = 4'hF;
  endtask

  task automatic select(input logic [3:0] m);
    bus.mode_sel_valid_in = 1'b1;
    bus.mode_sel_in       = m;
  endtask

  vec_t tbl [27];
  int   exp_seq [10];

  initial begin
    bus.auto_en_in = 1'b0;
    idle();
    for (int i = 0; i < 10; i++) exp_seq[i] = (i < 9) ? i + 1 : 1;

    //         sv sel   nx pv rv ra      m  sw er fc
    tbl[0]  = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd0, 0, 0, 16'd0);
    tbl[1]  = mk(1, 4'd3, 0, 0, 0, 4'h0, 4'd0, 1, 0, 16'd0);
    tbl[2]  = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd0, 1, 0, 16'd0);
    tbl[3]  = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd3, 0, 0, 16'd0);
    tbl[4]  = mk(1, 4'd12,0, 0, 0, 4'h0, 4'd3, 0, 1, 16'd0);
    tbl[5]  = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd3, 0, 0, 16'd0);
    tbl[6]  = mk(1, 4'd3, 0, 0, 0, 4'h0, 4'd3, 0, 0, 16'd0);
    tbl[7]  = mk(1, 4'd9, 0, 0, 0, 4'h0, 4'd3, 1, 0, 16'd0);
    tbl[8]  = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd3, 1, 0, 16'd0);
    tbl[9]  = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd9, 0, 0, 16'd0);
    tbl[10] = mk(0, 4'd0, 1, 0, 0, 4'h0, 4'd9, 1, 0, 16'd0);
    tbl[11] = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd9, 1, 0, 16'd0);
    tbl[12] = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd0, 0, 0, 16'd0);
    tbl[13] = mk(0, 4'd0, 0, 1, 0, 4'h0, 4'd0, 1, 0, 16'd0);
    tbl[14] = mk(0, 4'd0, 1, 1, 0, 4'h0, 4'd0, 1, 0, 16'd0);
    tbl[15] = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd0, 1, 0, 16'd0);
    tbl[16] = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd0, 0, 0, 16'd0);
    tbl[17] = mk(0, 4'd0, 1, 1, 0, 4'h0, 4'd0, 1, 0, 16'd0);
    tbl[18] = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd0, 1, 0, 16'd0);
    tbl[19] = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd1, 0, 0, 16'd0);
    tbl[20] = mk(1, 4'd4, 1, 0, 0, 4'h0, 4'd1, 1, 0, 16'd0);
    tbl[21] = mk(0, 4'd0, 0, 1, 0, 4'h0, 4'd1, 1, 0, 16'd0);
    tbl[22] = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd1, 1, 0, 16'd0);
    tbl[23] = mk(0, 4'd0, 0, 0, 0, 4'h0, 4'd3, 0, 0, 16'd0);
    tbl[24] = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd3, 0, 0, 16'd1);
    tbl[25] = mk(0, 4'd0, 0, 0, 1, 4'hF, 4'd3, 0, 0, 16'd2);
    tbl[26] = mk(0, 4'd0, 0, 0, 1, 4'hE, 4'd3, 0, 0, 16'd2);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mode", 32'(bus.mode_out), 32'd0);
    check("rst_switching", 32'(bus.switching_out), 32'd0);
    check("rst_sel_error", 32'(bus.sel_error_out), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifndef LED_SEQ_BLANK_FRAME_EN
    // Single-cycle vector table
    for (int i = 0; i < 27; i++) begin
      bus.mode_sel_valid_in = tbl[i].sv;
      bus.mode_sel_in       = tbl[i].sel;
      bus.next_in           = tbl[i].nx;
      bus.prev_in           = tbl[i].pv;
      bus.row_valid_in      = tbl[i].rv;
      bus.row_address_in    = tbl[i].ra;
      @(negedge clk);
      check($sformatf("vec%0d_mode", i), 32'(bus.mode_out), 32'(tbl[i].m));
      check($sformatf("vec%0d_switching", i), 32'(bus.switching_out), 32'(tbl[i].sw));
      check($sformatf("vec%0d_sel_error", i), 32'(bus.sel_error_out), 32'(tbl[i].er));
      check($sformatf("vec%0d_frame_count", i), 32'(bus.frame_count_out), 32'(tbl[i].fc));
    end
    idle();

    // Select 5, frame end 40 cycles later
    begin
      logic sw_ok;
      sw_ok = 1'b1;
      select(4'd5);
      @(negedge clk);
      idle();
      for (int i = 0; i < 40; i++) begin
        if (bus.switching_out !== 1'b1 || bus.mode_out !== 4'd3) sw_ok = 1'b0;
        @(negedge clk);
      end
      check("wait40_switching_held", 32'(sw_ok), 32'd1);
      frame_end();
      @(negedge clk);
      idle();
      check("wait40_mode_after_1", 32'(bus.mode_out), 32'd3);
      check("wait40_switch_after_1", 32'(bus.switching_out), 32'd1);
      @(negedge clk);
      check("wait40_mode_after_2", 32'(bus.mode_out), 32'd5);
      check("wait40_switch_after_2", 32'(bus.switching_out), 32'd0);
      check("wait40_fc_cleared", 32'(bus.frame_count_out), 32'd0);
      frame_end();
      @(negedge clk);
      idle();
      check("fc_incr_1", 32'(bus.frame_count_out), 32'd1);
    end

    // Forced commit after FT cycles with no frame ends
    select(4'd7);
    @(negedge clk);
    idle();
    repeat (FT) @(negedge clk);
    check("timeout_mode_before", 32'(bus.mode_out), 32'd5);
    check("timeout_switch_before", 32'(bus.switching_out), 32'd1);
    @(negedge clk);
    check("timeout_mode_after", 32'(bus.mode_out), 32'd7);
    check("timeout_switch_after", 32'(bus.switching_out), 32'd0);
`else
    // Blank frame: 0 -> 2, then 2 -> dark frame -> 5
    select(4'd2);
    @(negedge clk);
    frame_end();
    @(negedge clk);
    frame_end();
    @(negedge clk);
    idle();
    @(negedge clk);
    check("blank_mode_2", 32'(bus.mode_out), 32'd2);
    select(4'd5);
    @(negedge clk);
    idle();
    check("blank_pending_mode", 32'(bus.mode_out), 32'd2);
    check("blank_pending_switch", 32'(bus.switching_out), 32'd1);
    frame_end();
    @(negedge clk);
    idle();
    check("blank_dark_mode", 32'(bus.mode_out), 32'd0);
    repeat (5) @(negedge clk);
    check("blank_dark_hold", 32'(bus.mode_out), 32'd0);
    check("blank_dark_switch", 32'(bus.switching_out), 32'd1);
    frame_end();
    @(negedge clk);
    idle();
    check("blank_commit_cycle", 32'(bus.mode_out), 32'd0);
    @(negedge clk);
    check("blank_new_mode", 32'(bus.mode_out), 32'd5);
    check("blank_switch_done", 32'(bus.switching_out), 32'd0);
    check("blank_fc_cleared", 32'(bus.frame_count_out), 32'd0);
    frame_end();
    @(negedge clk);
    idle();
    check("blank_fc_incr", 32'(bus.frame_count_out), 32'd1);
`endif

    // Return to OFF, then auto-cycle with frame ends every 50 cycles
    select(4'd0);
    @(negedge clk);
    frame_end();
    @(negedge clk);
    frame_end();
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    check("auto_start_mode", 32'(bus.mode_out), 32'd0);
    bus.auto_en_in = 1'b1;
    begin
      int          k;
      logic [3:0]  last;
      k    = 0;
      last = bus.mode_out;
      for (int cyc = 0; cyc < 6000 && k < 10; cyc++) begin
        if ((cyc % 50) == 49) frame_end();
        else idle();
        @(negedge clk);
        if (bus.mode_out !== last) begin
          last = bus.mode_out;
`ifdef LED_SEQ_BLANK_FRAME_EN
          if (last != 4'd0) begin
            check($sformatf("auto_seq%0d", k), 32'(last), 32'(exp_seq[k]));
            k++;
          end
`else
          check($sformatf("auto_seq%0d", k), 32'(last), 32'(exp_seq[k]));
          k++;
`endif
        end
      end
      if (k < 10) check("auto_budget", 32'(k), 32'd10);
    end
    bus.auto_en_in = 1'b0;
    idle();
    @(negedge clk);

    // Asynchronous reset while a change is pending
    select(4'd4);
    @(negedge clk);
    idle();
    check("pre_reset_switching", 32'(bus.switching_out), 32'd1);
    check("pre_reset_mode", 32'(bus.mode_out), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_mode", 32'(bus.mode_out), 32'd0);
    check("async_rst_switching", 32'(bus.switching_out), 32'd0);
    check("async_rst_fc", 32'(bus.frame_count_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_switching", 32'(bus.switching_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
